pipe_chain: RTL and testbench

- Parametrised multi-stage elastic pipeline register with a valid/ready handshake on both ends.
- Each stage carries one W-bit word plus a valid bit.
- Bubbles collapse under backpressure, and a synchronous flush empties every stage.
- Used between processor pipeline sections where a stage may stall independently, e.g. decode->execute or the memory response path.

---
 rtl/pipe_chain_if.sv | 24 ++
 rtl/pipe_chain.sv | 95 +++++++++
 tb/tb_pipe_chain.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_chain_if.sv
// pipe_chain_if: valid/ready handshake bundle for pipe_chain.
//   Upstream side  : in_valid, in_data  -> chain, in_ready  <- chain
//   Downstream side: out_valid, out_data <- chain, out_ready -> chain
// Modports: master = the environment driving the chain, slave = the chain itself.
interface pipe_chain_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_chain.sv
// pipe_chain: multi-stage elastic pipeline register with valid/ready on both ends.
// Empty stages always accept from their predecessor, so bubbles collapse under
// backpressure; flush clears every valid bit synchronously.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (overrides flush and handshakes)
//   flush     synchronous clear of all stages; blocks both handshakes in its cycle
//   bus       pipe_chain_if.slave: in_valid/in_data/in_ready, out_valid/out_data/out_ready
//   occupancy number of valid stages (only with PIPE_CHAIN_OCC_EN defined)
// Optional feature macro: PIPE_CHAIN_OCC_EN adds the registered occupancy counter.
module pipe_chain #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  pipe_chain_if.slave                 bus
`ifdef PIPE_CHAIN_OCC_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

  logic [STAGES-1:0] valid_q;
  logic [W-1:0]      data_q [STAGES];
  logic [STAGES-1:0] adv;

  // Ripple the move condition from the output side back to stage 0; a running
  // scalar avoids a vector that reads its own bits.
  always_comb begin
    logic a;
    adv = '0;
    a = !valid_q[STAGES-1] || bus.out_ready;
    adv[STAGES-1] = a;
    for (int i = STAGES - 2; i >= 0; i--) begin
      a = !valid_q[i] || a;
      adv[i] = a;
    end
  end

  assign bus.in_ready  = adv[0] && !flush;
  assign bus.out_valid = valid_q[STAGES-1] && !flush;
  assign bus.out_data  = bus.out_valid ? data_q[STAGES-1] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else if (flush) begin
      // data is left as-is; it is invisible once valid is cleared
      valid_q <= '0;
    end else begin
      if (adv[0]) begin
        valid_q[0] <= bus.in_valid;
        if (bus.in_valid) data_q[0] <= bus.in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end
  end

`ifdef PIPE_CHAIN_OCC_EN
  localparam int OW = $clog2(STAGES + 1);

  logic          in_xfer;
  logic          out_xfer;
  logic [OW-1:0] occ_q;

  assign in_xfer   = bus.in_valid && bus.in_ready;
  assign out_xfer  = bus.out_valid && bus.out_ready;
  assign occupancy = occ_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ_q <= occ_q + OW'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_q <= occ_q - OW'(1);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert (occ_q == OW'($countones(valid_q)));
  end
`endif
`endif

endmodule

// File: tb/tb_pipe_chain.sv
module tb_pipe_chain;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_chk = 0;
  int   n_err = 0;
  int   step  = 0;
  logic [7:0] q [$];

  always #5 clk = ~clk;

  pipe_chain_if #(.W(8)) bus3 ();
  pipe_chain_if #(.W(8)) bus4 ();

`ifdef PIPE_CHAIN_OCC_EN
  logic [1:0] occ3;
  logic [2:0] occ4;
`endif

  pipe_chain #(.W(8), .STAGES(3)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus3)
`ifdef PIPE_CHAIN_OCC_EN
    ,
    .occupancy (occ3)
`endif
  );

  pipe_chain #(.W(8), .STAGES(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus4)
`ifdef PIPE_CHAIN_OCC_EN
    ,
    .occupancy (occ4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_occ3(input int exp);
`ifdef PIPE_CHAIN_OCC_EN
    chk($sformatf("occ3@%0d", step), 32'(occ3), 32'(exp));
`endif
  endtask

  // One cycle on dut3: drive, let it settle, check combinational outputs, advance.
  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy, input logic fl,
                     input logic e_ir, input logic e_ov, input logic [7:0] e_od);
    bus3.in_valid  = v;
    bus3.in_data   = d;
    bus3.out_ready = ordy;
    flush          = fl;
    #2;
    chk($sformatf("in_ready@%0d", step),  32'(bus3.in_ready),  32'(e_ir));
    chk($sformatf("out_valid@%0d", step), 32'(bus3.out_valid), 32'(e_ov));
    chk($sformatf("out_data@%0d", step),  32'(bus3.out_data),  32'(e_od));
    step++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk_occ3(0);
    cyc(0, 8'h00, 0, 0, 1, 0, 8'h00);

    // stream with out_ready=1: first output two cycles after the accept edge's next cycle
    cyc(1, 8'h11, 1, 0, 1, 0, 8'h00);
    cyc(1, 8'h22, 1, 0, 1, 0, 8'h00);
    cyc(1, 8'h33, 1, 0, 1, 0, 8'h00);
    cyc(1, 8'h44, 1, 0, 1, 1, 8'h11);
    cyc(0, 8'h99, 1, 0, 1, 1, 8'h22);
    cyc(0, 8'h99, 1, 0, 1, 1, 8'h33);
    cyc(0, 8'h99, 1, 0, 1, 1, 8'h44);
    cyc(0, 8'h99, 1, 0, 1, 0, 8'h00);

    // backpressure fill, then one release cycle
    cyc(1, 8'hA1, 0, 0, 1, 0, 8'h00);
    cyc(1, 8'hA2, 0, 0, 1, 0, 8'h00);
    cyc(1, 8'hA3, 0, 0, 1, 0, 8'h00);
    chk_occ3(3);
    cyc(1, 8'hA4, 0, 0, 0, 1, 8'hA1);
    cyc(1, 8'hA4, 1, 0, 1, 1, 8'hA1);
    cyc(0, 8'h00, 1, 0, 1, 1, 8'hA2);
    cyc(0, 8'h00, 1, 0, 1, 1, 8'hA3);
    cyc(0, 8'h00, 1, 0, 1, 1, 8'hA4);
    chk_occ3(0);
    cyc(0, 8'h00, 1, 0, 1, 0, 8'h00);

    // bubble collapse: {1,0,1} -> {0,1,1} with out_ready=0
    cyc(1, 8'hB1, 0, 0, 1, 0, 8'h00);
    cyc(0, 8'h00, 0, 0, 1, 0, 8'h00);
    cyc(1, 8'hB2, 0, 0, 1, 0, 8'h00);
    chk("bubble_pre", 32'(dut3.valid_q), 32'h5);
    cyc(0, 8'h00, 0, 0, 1, 1, 8'hB1);
    chk("bubble_post", 32'(dut3.valid_q), 32'h6);
    chk_occ3(2);
    cyc(0, 8'h00, 1, 0, 1, 1, 8'hB1);
    cyc(0, 8'h00, 1, 0, 1, 1, 8'hB2);
    cyc(0, 8'h00, 1, 0, 1, 0, 8'h00);

    // flush of a full chain, then back-to-back flushes
    cyc(1, 8'h01, 0, 0, 1, 0, 8'h00);
    cyc(1, 8'h02, 0, 0, 1, 0, 8'h00);
    cyc(1, 8'h03, 0, 0, 1, 0, 8'h00);
    chk_occ3(3);
    cyc(1, 8'h04, 1, 1, 0, 0, 8'h00);
    chk_occ3(0);
    cyc(0, 8'h00, 1, 0, 1, 0, 8'h00);
    cyc(1, 8'h05, 1, 1, 0, 0, 8'h00);
    cyc(1, 8'h06, 1, 1, 0, 0, 8'h00);
    cyc(0, 8'h00, 1, 0, 1, 0, 8'h00);
    cyc(0, 8'h00, 1, 0, 1, 0, 8'h00);
    chk_occ3(0);

    // reset together with flush and in_valid
    cyc(1, 8'h55, 0, 0, 1, 0, 8'h00);
    cyc(1, 8'h66, 0, 0, 1, 0, 8'h00);
    rst = 1'b1;
    cyc(1, 8'h77, 1, 1, 0, 0, 8'h00);
    rst = 1'b0;
    chk_occ3(0);
    cyc(0, 8'h00, 1, 0, 1, 0, 8'h00);
    cyc(1, 8'h88, 1, 0, 1, 0, 8'h00);
    cyc(0, 8'h00, 1, 0, 1, 0, 8'h00);
    cyc(0, 8'h00, 1, 0, 1, 0, 8'h00);
    cyc(0, 8'h00, 1, 0, 1, 1, 8'h88);
    cyc(0, 8'h00, 1, 0, 1, 0, 8'h00);

    // random traffic on the 4-stage chain against a FIFO model
    for (int t = 0; t < 200; t++) begin
      bus4.in_valid  = 1'($urandom_range(0, 1));
      bus4.in_data   = 8'($urandom);
      bus4.out_ready = 1'($urandom_range(0, 1));
      #2;
      chk($sformatf("r_in_ready@%0d", t), 32'(bus4.in_ready),
          32'((q.size() < 4) || bus4.out_ready));
`ifdef PIPE_CHAIN_OCC_EN
      chk($sformatf("r_occ@%0d", t), 32'(occ4), 32'(q.size()));
      chk($sformatf("r_occmax@%0d", t), 32'(occ4 <= 3'd4), 32'd1);
`endif
      if (!bus4.out_valid) chk($sformatf("r_gate@%0d", t), 32'(bus4.out_data), 32'd0);
      if (bus4.out_valid && bus4.out_ready) begin
        if (q.size() == 0) chk($sformatf("r_spurious@%0d", t), 32'd1, 32'd0);
        else chk($sformatf("r_data@%0d", t), 32'(bus4.out_data), 32'(q.pop_front()));
      end
      if (bus4.in_valid && bus4.in_ready) q.push_back(bus4.in_data);
      @(posedge clk);
      #1;
    end

    // drain: every outstanding word must come out in order within the budget
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      #2;
      if (bus4.out_valid) begin
        if (q.size() == 0) chk($sformatf("d_spurious@%0d", t), 32'd1, 32'd0);
        else chk($sformatf("d_data@%0d", t), 32'(bus4.out_data), 32'(q.pop_front()));
      end
      @(posedge clk);
      #1;
    end
    chk("d_left", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
